// File: rtl/arb_pkg.sv
// ============================================================================
//  Module      : arb_pkg
//  Description : Shared state encoding, error fill and index-width helper for
//                the memory arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package arb_pkg;

    typedef logic [1:0] arb_state_t;

    localparam arb_state_t IDLE  = 2'd0;
    localparam arb_state_t ISSUE = 2'd1;
    localparam arb_state_t RESP  = 2'd2;

    // Fill bit for readdata when a transaction is abandoned by the watchdog.
    localparam logic ERR_FILL = 1'b1;

    function automatic int arb_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_picker.sv
// ============================================================================
//  Module      : rr_picker
//  Description : Combinational round-robin pick: first set request after
//                index 'last', wrapping modulo NUM_CORES.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_picker #(
    parameter int NUM_CORES = 4,
    parameter int IDX_W     = 2
) (
    input  logic [NUM_CORES-1:0] req,
    input  logic [IDX_W-1:0]     last,
    output logic [IDX_W-1:0]     grant_idx,
    output logic                 any_req
);

    int w_idx;

    // Scan from the farthest offset down so the nearest requester wins.
    always_comb begin
        grant_idx = '0;
        any_req   = 1'b0;
        w_idx     = 0;
        for (int k = NUM_CORES; k >= 1; k--) begin
            w_idx = (int'(last) + k) % NUM_CORES;
            if (req[w_idx]) begin
                grant_idx = IDX_W'(w_idx);
                any_req   = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
//  Module      : mem_arbiter
//  Description : Round-robin arbiter sharing one memory port among NUM_CORES
//                cores, one outstanding transaction at a time.
//                Define ARB_TIMEOUT_EN to enable the ISSUE-state watchdog.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arbiter
    import arb_pkg::*;
#(
    parameter int NUM_CORES      = 4,
    parameter int WIDTH          = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_CORES-1:0]            request,
    input  logic [NUM_CORES-1:0]            wren,
    input  logic [NUM_CORES*ADDR_WIDTH-1:0] address,
    input  logic [NUM_CORES*WIDTH-1:0]      writedata,
    output logic [NUM_CORES-1:0]            response,
    output logic [WIDTH-1:0]                readdata,
    output logic                            bus_error,
    output logic                            mem_request,
    output logic                            mem_wren,
    output logic [ADDR_WIDTH-1:0]           mem_address,
    output logic [WIDTH-1:0]                mem_writedata,
    input  logic [WIDTH-1:0]                mem_readdata,
    input  logic                            mem_response
);

    localparam int IDX_W = arb_idx_w(NUM_CORES);

    arb_state_t             r_state;
    arb_state_t             w_next_state;
    logic [IDX_W-1:0]       r_rr_last;
    logic [IDX_W-1:0]       r_grant;
    logic [IDX_W-1:0]       w_pick_idx;
    logic                   w_any_req;
    logic                   w_timeout;
    logic                   w_err_flag;
    logic                   r_mem_wren;
    logic [ADDR_WIDTH-1:0]  r_mem_address;
    logic [WIDTH-1:0]       r_mem_writedata;
    logic [WIDTH-1:0]       r_readdata;
    logic [ADDR_WIDTH-1:0]  w_addr_arr  [NUM_CORES];
    logic [WIDTH-1:0]       w_wdata_arr [NUM_CORES];

    if (NUM_CORES < 2 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("mem_arbiter: NUM_CORES must be >= 2 and TIMEOUT_CYCLES >= 1");
    end

    for (genvar i = 0; i < NUM_CORES; i++) begin : g_unpack
        assign w_addr_arr[i]  = address[i*ADDR_WIDTH +: ADDR_WIDTH];
        assign w_wdata_arr[i] = writedata[i*WIDTH +: WIDTH];
    end

    rr_picker #(
        .NUM_CORES (NUM_CORES),
        .IDX_W     (IDX_W)
    ) u_picker (
        .req       (request),
        .last      (r_rr_last),
        .grant_idx (w_pick_idx),
        .any_req   (w_any_req)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_any_req) w_next_state = ISSUE;
            ISSUE:   if (mem_response || w_timeout) w_next_state = RESP;
            RESP:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Outputs decode from state only, so an async reset clears them at once.
    always_comb begin
        mem_request = (r_state == ISSUE);
        response    = '0;
        bus_error   = 1'b0;
        if (r_state == RESP) begin
            response[r_grant] = 1'b1;
            bus_error         = w_err_flag;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_grant         <= '0;
            r_rr_last       <= IDX_W'(NUM_CORES - 1);
            r_mem_wren      <= 1'b0;
            r_mem_address   <= '0;
            r_mem_writedata <= '0;
            r_readdata      <= '0;
        end else begin
            if (r_state == IDLE && w_any_req) begin
                r_grant         <= w_pick_idx;
                r_mem_wren      <= wren[w_pick_idx];
                r_mem_address   <= w_addr_arr[w_pick_idx];
                r_mem_writedata <= w_wdata_arr[w_pick_idx];
            end
            if (r_state == ISSUE && (mem_response || w_timeout)) begin
                r_rr_last  <= r_grant;
                r_readdata <= mem_response ? mem_readdata : {WIDTH{ERR_FILL}};
            end
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WD_W-1:0] r_wd_cnt;
    logic            r_timed_out;

    // A response arriving on the final watchdog cycle still wins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wd_cnt    <= '0;
            r_timed_out <= 1'b0;
        end else if (r_state == ISSUE) begin
            r_wd_cnt    <= r_wd_cnt + WD_W'(1);
            r_timed_out <= w_timeout && !mem_response;
        end else begin
            r_wd_cnt    <= '0;
        end
    end

    assign w_timeout  = (r_state == ISSUE) && (r_wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));
    assign w_err_flag = r_timed_out;
`else
    assign w_timeout  = 1'b0;
    assign w_err_flag = 1'b0;
`endif

    assign readdata      = r_readdata;
    assign mem_wren      = r_mem_wren;
    assign mem_address   = r_mem_address;
    assign mem_writedata = r_mem_writedata;

endmodule

`default_nettype wire
